// File: rtl/instr_encoder.sv
// instr_encoder: turns structured instruction requests into 32-bit MIPS words
// for the single-cycle core subset (addu, subu, and, or, sltu, lw, sw, beq,
// addiu, j). A program counter tracks the byte address of each emitted word,
// so beq offsets and j fields are computed from the word's own position.
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. A producer holds its payload stable while valid && !ready. in_ready is
// combinational (!out_valid || out_ready), so a transfer-out and an accept can
// share a cycle and the block sustains one word per clock. No FSM: the only
// state is the one-entry output register, pc and the sticky error.
module instr_encoder #(
  parameter logic [31:0] START_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_kind,
  input  logic [2:0]  in_alu,
  input  logic [4:0]  in_rs,
  input  logic [4:0]  in_rt,
  input  logic [4:0]  in_rd,
  input  logic [15:0] in_imm,
  input  logic [31:0] in_target,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_addr,
  output logic        err,
  output logic [1:0]  err_code
);

  localparam logic [2:0] KIND_ALU   = 3'd0;
  localparam logic [2:0] KIND_LW    = 3'd1;
  localparam logic [2:0] KIND_SW    = 3'd2;
  localparam logic [2:0] KIND_BEQ   = 3'd3;
  localparam logic [2:0] KIND_ADDIU = 3'd4;
  localparam logic [2:0] KIND_J     = 3'd5;

  localparam logic [1:0] ERR_NONE   = 2'd0;
  localparam logic [1:0] ERR_KIND   = 2'd1;
  localparam logic [1:0] ERR_BRANCH = 2'd2;
  localparam logic [1:0] ERR_JUMP   = 2'd3;

  logic [31:0]        pc;
  logic [31:0]        pc_plus4;
  logic [31:0]        beq_diff;
  logic signed [31:0] beq_off;
  logic               beq_range_ok;
  logic               accept;
  logic [31:0]        enc_word;
  logic               enc_err;
  logic [1:0]         enc_code;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign pc_plus4 = pc + 32'd4;

  // Branch offset: word distance from the delay-slot address, arithmetic shift
  // keeps the sign. It fits a 16-bit field only if bits 31..15 are all equal.
  always_comb begin
    beq_diff     = in_target - pc_plus4;
    beq_off      = $signed(beq_diff) >>> 2;
    beq_range_ok = (beq_off[31:15] == 17'h00000) || (beq_off[31:15] == 17'h1FFFF);
  end

  // Encode the current request; any error replaces the word with a nop.
  always_comb begin
    enc_word = 32'h0000_0000;
    enc_err  = 1'b0;
    enc_code = ERR_NONE;
    case (in_kind)
      KIND_ALU: begin
        case (in_alu)
          3'd0: enc_word = {6'b000000, in_rs, in_rt, in_rd, 5'd0, 6'b100001};
          3'd1: enc_word = {6'b000000, in_rs, in_rt, in_rd, 5'd0, 6'b100011};
          3'd2: enc_word = {6'b000000, in_rs, in_rt, in_rd, 5'd0, 6'b100100};
          3'd3: enc_word = {6'b000000, in_rs, in_rt, in_rd, 5'd0, 6'b100101};
          3'd4: enc_word = {6'b000000, in_rs, in_rt, in_rd, 5'd0, 6'b101011};
          default: begin
            enc_err  = 1'b1;
            enc_code = ERR_KIND;
          end
        endcase
      end
      KIND_LW:    enc_word = {6'b100011, in_rs, in_rt, in_imm};
      KIND_SW:    enc_word = {6'b101011, in_rs, in_rt, in_imm};
      KIND_ADDIU: enc_word = {6'b001001, in_rs, in_rt, in_imm};
      KIND_BEQ: begin
        if ((in_target[1:0] != 2'b00) || !beq_range_ok) begin
          enc_err  = 1'b1;
          enc_code = ERR_BRANCH;
        end else begin
          enc_word = {6'b000100, in_rs, in_rt, beq_off[15:0]};
        end
      end
      KIND_J: begin
        if ((in_target[1:0] != 2'b00) || (in_target[31:28] != pc_plus4[31:28])) begin
          enc_err  = 1'b1;
          enc_code = ERR_JUMP;
        end else begin
          enc_word = {6'b000010, in_target[27:2]};
        end
      end
      default: begin
        enc_err  = 1'b1;
        enc_code = ERR_KIND;
      end
    endcase
    if (enc_err) begin
      enc_word = 32'h0000_0000;
    end
  end

  // Output register, pc and sticky error; the first error code wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc        <= START_PC;
      out_valid <= 1'b0;
      out_instr <= 32'h0000_0000;
      out_addr  <= 32'h0000_0000;
      err       <= 1'b0;
      err_code  <= ERR_NONE;
    end else begin
      if (accept) begin
        out_valid <= 1'b1;
        out_instr <= enc_word;
        out_addr  <= pc;
        pc        <= pc_plus4;
        if (enc_err) begin
          err <= 1'b1;
          if (err_code == ERR_NONE) begin
            err_code <= enc_code;
          end
        end
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
